// File: rtl/register_file.sv
// General-purpose register file: two combinational read ports, one write port
// clocked on the rising edge of in_clk, asynchronous active-low clear.
module register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 256
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic [ADDR_WIDTH-1:0] in_read_reg_1_add,
    input  logic [ADDR_WIDTH-1:0] in_read_reg_2_add,
    input  logic [ADDR_WIDTH-1:0] in_write_reg_add,
    input  logic [DATA_WIDTH-1:0] in_write_reg_val,
    input  logic                  in_write_en,
    output logic [DATA_WIDTH-1:0] out_reg_1_val,
    output logic [DATA_WIDTH-1:0] out_reg_2_val
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_sel;

    // One-hot write decode; out-of-range addresses match no register.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_dec
            assign wr_sel[gi] = in_write_en && (in_write_reg_add == ADDR_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs_reg[i] <= in_write_reg_val;
                end
            end
        end
    end

    logic             rd1_in_range;
    logic             rd2_in_range;
    logic [IDX_W-1:0] rd1_idx;
    logic [IDX_W-1:0] rd2_idx;

    assign rd1_in_range = ({{(32-ADDR_WIDTH){1'b0}}, in_read_reg_1_add} < 32'(NUM_REGS));
    assign rd2_in_range = ({{(32-ADDR_WIDTH){1'b0}}, in_read_reg_2_add} < 32'(NUM_REGS));
    assign rd1_idx      = in_read_reg_1_add[IDX_W-1:0];
    assign rd2_idx      = in_read_reg_2_add[IDX_W-1:0];

    // No write bypass: reads always reflect the stored contents.
    always_comb begin
        out_reg_1_val = '0;
        out_reg_2_val = '0;
        if (in_rst && rd1_in_range) begin
            out_reg_1_val = regs_reg[rd1_idx];
        end
        if (in_rst && rd2_in_range) begin
            out_reg_2_val = regs_reg[rd2_idx];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed test of register_file: a full 256-entry instance and a 200-entry
// instance sharing the same stimulus, checked with immediate assertions.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [7:0]  rd1_add;
    logic [7:0]  rd2_add;
    logic [7:0]  wr_add;
    logic [15:0] wr_val;
    logic        wr_en;
    logic [15:0] a_out1;
    logic [15:0] a_out2;
    logic [15:0] b_out1;
    logic [15:0] b_out2;

    int checks = 0;
    int errors = 0;

    register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_REGS(256)) dut_a (
        .in_clk            (clk),
        .in_rst            (rst),
        .in_read_reg_1_add (rd1_add),
        .in_read_reg_2_add (rd2_add),
        .in_write_reg_add  (wr_add),
        .in_write_reg_val  (wr_val),
        .in_write_en       (wr_en),
        .out_reg_1_val     (a_out1),
        .out_reg_2_val     (a_out2)
    );

    register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_REGS(200)) dut_b (
        .in_clk            (clk),
        .in_rst            (rst),
        .in_read_reg_1_add (rd1_add),
        .in_read_reg_2_add (rd2_add),
        .in_write_reg_add  (wr_add),
        .in_write_reg_val  (wr_val),
        .in_write_en       (wr_en),
        .out_reg_1_val     (b_out1),
        .out_reg_2_val     (b_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] a, input logic [15:0] v);
        wr_add = a;
        wr_val = v;
        wr_en  = 1'b1;
        tick();
        wr_en  = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a1, input logic [7:0] a2);
        rd1_add = a1;
        rd2_add = a2;
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        rd1_add = 8'd0;
        rd2_add = 8'd255;
        wr_add  = 8'd7;
        wr_val  = 16'hAAAA;
        wr_en   = 1'b1;
        #2 rst  = 1'b0;

        // Reset held with a write attempted on live edges.
        tick();
        tick();
        rd(8'd0, 8'd255);
        chk("rst_rd0", a_out1, 16'h0000);
        chk("rst_rd255", a_out2, 16'h0000);
        rst   = 1'b1;
        wr_en = 1'b0;
        rd(8'd7, 8'd7);
        chk("rst_wr_ignored", a_out1, 16'h0000);

        // Back-to-back writes, then paired reads.
        write(8'd0, 16'd10);
        write(8'd1, 16'd11);
        write(8'd2, 16'd12);
        rd(8'd0, 8'd1);
        chk("seq_r0", a_out1, 16'd10);
        chk("seq_r1", a_out2, 16'd11);
        rd(8'd1, 8'd2);
        chk("seq_r1b", a_out1, 16'd11);
        chk("seq_r2", a_out2, 16'd12);

        // Write enable low leaves the target untouched.
        wr_add = 8'd3;
        wr_val = 16'hBEEF;
        wr_en  = 1'b0;
        repeat (3) tick();
        rd(8'd3, 8'd0);
        chk("wr_dis_r3", a_out1, 16'h0000);

        // Read-during-write shows old value until the edge.
        write(8'd5, 16'h1111);
        rd(8'd5, 8'd0);
        wr_add = 8'd5;
        wr_val = 16'h2222;
        wr_en  = 1'b1;
        #1;
        chk("rdw_before", a_out1, 16'h1111);
        tick();
        wr_en = 1'b0;
        chk("rdw_after", a_out1, 16'h2222);

        // Full-width value, both ports on one address.
        write(8'd255, 16'hFFFF);
        rd(8'd255, 8'd255);
        chk("r255_p1", a_out1, 16'hFFFF);
        chk("r255_p2", a_out2, 16'hFFFF);
        chk("b_r255_oor", b_out1, 16'h0000);

        // Out-of-range write on the 200-entry instance.
        write(8'd200, 16'h1234);
        rd(8'd200, 8'd0);
        chk("b_r200_oor", b_out1, 16'h0000);
        chk("b_r0", b_out2, 16'd10);
        chk("a_r200", a_out1, 16'h1234);
        rd(8'd8, 8'd199);
        chk("b_r8", b_out1, 16'h0000);
        chk("b_r199", b_out2, 16'h0000);

        // Asynchronous clear mid-cycle, with a write pending through reset.
        rd(8'd0, 8'd255);
        wr_add = 8'd9;
        wr_val = 16'h5555;
        wr_en  = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("async_r0", a_out1, 16'h0000);
        chk("async_r255", a_out2, 16'h0000);
        tick();
        rst   = 1'b1;
        wr_en = 1'b0;
        rd(8'd0, 8'd255);
        chk("post_rst_r0", a_out1, 16'h0000);
        chk("post_rst_r255", a_out2, 16'h0000);
        rd(8'd9, 8'd2);
        chk("lost_wr_r9", a_out1, 16'h0000);
        chk("post_rst_r2", a_out2, 16'h0000);

        // First edge after release performs a write.
        write(8'd9, 16'h8001);
        rd(8'd9, 8'd9);
        chk("first_wr_r9", a_out1, 16'h8001);
        chk("b_first_wr_r9", b_out2, 16'h8001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
